// File: rtl/series_term_controller.sv
// ---------------------------------------------------------------------------
// series_term_controller
//
// Sequencer for a series-expansion datapath made of an operand register X,
// a term register Tmp, an accumulator Acc, a multiplier and a coefficient
// ROM holding 1/k. For each accepted operand it runs TERMS rounds of
//     Acc += Tmp(k);  Tmp(k+1) = Tmp(k) * X * coef[k+1]
// and then offers the accumulated result to the consumer.
//
// Parameters
//   TERMS  number of series terms summed (k = 0..TERMS-1), 1..2**CNT_W
//   CNT_W  width of the term counter and of coefAddr
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operand available on the datapath input
//   in_ready   controller can accept an operand (IDLE)
//   out_valid  Acc holds the final result (DONE)
//   out_ready  consumer takes the result
//   out_err    overflow occurred during this operation (with out_valid)
//   abort      synchronous cancel of the running operation
//   ovf        datapath overflow flag from multiplier/adder
//   ldX        load X from the input
//   selTmp     Tmp mux select: 0 = constant 1.0, 1 = multiplier output
//   ldTmp      load Tmp
//   clrAcc     clear Acc to 0
//   ldAcc      load Acc with Acc + Tmp
//   coefAddr   coefficient ROM address (non-zero only while multiplying)
//   busy       high in every state except IDLE
// ---------------------------------------------------------------------------
module series_term_controller #(
    parameter int TERMS = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_err,
    input  logic             abort,
    input  logic             ovf,
    output logic             ldX,
    output logic             selTmp,
    output logic             ldTmp,
    output logic             clrAcc,
    output logic             ldAcc,
    output logic [CNT_W-1:0] coefAddr,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ADD  = 3'd2,
        S_MUL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Index of the last term; the counter never advances past it.
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(TERMS - 1);
    localparam logic [CNT_W-1:0] K_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_k;
    logic             r_err;

    // Registered copies of the Moore outputs.
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_out_err;
    logic             r_ldX;
    logic             r_selTmp;
    logic             r_ldTmp;
    logic             r_clrAcc;
    logic             r_ldAcc;
    logic [CNT_W-1:0] r_coefAddr;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_k_nxt;
    logic             w_err_nxt;

    // Next-state logic. In the working states abort wins over ovf, and ovf
    // wins over the normal ADD/MUL ping-pong.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_k_nxt   = '0;
                w_err_nxt = 1'b0;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (ovf) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_k == K_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                // MUL is only reached with k < K_LAST, so k+1 cannot wrap.
                w_k_nxt = r_k + K_ONE;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (ovf) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_ADD;
                end
            end
            S_DONE: begin
                // Result is held until taken; abort has no effect here.
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counter, error flag and the outputs are registered together.
    // Outputs are decoded from the state being entered, so each output
    // register always equals the Moore decode of r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_ldX       <= 1'b0;
            r_selTmp    <= 1'b0;
            r_ldTmp     <= 1'b0;
            r_clrAcc    <= 1'b0;
            r_ldAcc     <= 1'b0;
            r_coefAddr  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_err       <= w_err_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_out_err   <= (w_state_nxt == S_DONE) && w_err_nxt;
            r_ldX       <= (w_state_nxt == S_LOAD);
            r_clrAcc    <= (w_state_nxt == S_LOAD);
            r_ldTmp     <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_MUL);
            r_selTmp    <= (w_state_nxt == S_MUL);
            r_ldAcc     <= (w_state_nxt == S_ADD);
            // While in MUL the counter still holds the index of the term just
            // added; the ROM must present the coefficient of the next term.
            r_coefAddr  <= (w_state_nxt == S_MUL) ? (w_k_nxt + K_ONE) : '0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_err   = r_out_err;
    assign ldX       = r_ldX;
    assign selTmp    = r_selTmp;
    assign ldTmp     = r_ldTmp;
    assign clrAcc    = r_clrAcc;
    assign ldAcc     = r_ldAcc;
    assign coefAddr  = r_coefAddr;
    assign busy      = r_busy;

endmodule

// File: tb/tb_series_term_controller.sv
module tb_series_term_controller;

    logic       clk;
    logic       rst;

    // TERMS = 8 instance
    logic       in_valid, out_ready, abort, ovf;
    logic       in_ready, out_valid, out_err;
    logic       ldX, selTmp, ldTmp, clrAcc, ldAcc, busy;
    logic [2:0] coefAddr;

    // TERMS = 1 instance
    logic       t1_in_valid, t1_out_ready, t1_abort, t1_ovf;
    logic       t1_in_ready, t1_out_valid, t1_out_err;
    logic       t1_ldX, t1_selTmp, t1_ldTmp, t1_clrAcc, t1_ldAcc, t1_busy;
    logic [2:0] t1_coefAddr;

    int n_tests = 0;
    int n_fail  = 0;

    series_term_controller #(.TERMS(8), .CNT_W(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err),
        .abort     (abort),
        .ovf       (ovf),
        .ldX       (ldX),
        .selTmp    (selTmp),
        .ldTmp     (ldTmp),
        .clrAcc    (clrAcc),
        .ldAcc     (ldAcc),
        .coefAddr  (coefAddr),
        .busy      (busy)
    );

    series_term_controller #(.TERMS(1), .CNT_W(3)) u_dut_t1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (t1_in_valid),
        .in_ready  (t1_in_ready),
        .out_valid (t1_out_valid),
        .out_ready (t1_out_ready),
        .out_err   (t1_out_err),
        .abort     (t1_abort),
        .ovf       (t1_ovf),
        .ldX       (t1_ldX),
        .selTmp    (t1_selTmp),
        .ldTmp     (t1_ldTmp),
        .clrAcc    (t1_clrAcc),
        .ldAcc     (t1_ldAcc),
        .coefAddr  (t1_coefAddr),
        .busy      (t1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle operand handshake; returns sampling the LOAD state.
    task automatic start_op();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Step until out_valid, bounded; n = edges taken.
    task automatic wait_ov(input int limit, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        chk("wait_out_valid", out_valid, 1);
    endtask

    initial begin
        int n;
        int n_add, n_mul, n_ov;
        int exp_coef;

        rst = 1'b1;
        in_valid = 0; out_ready = 1; abort = 0; ovf = 0;
        t1_in_valid = 0; t1_out_ready = 1; t1_abort = 0; t1_ovf = 0;
        #12;

        // Reset values
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_coef", coefAddr, 0);
        chk("rst_ctl", {ldX, selTmp, ldTmp, clrAcc, ldAcc, out_err}, 0);
        chk("rst_t1_in_ready", t1_in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Nominal TERMS=8 operation
        start_op();
        chk("load_in_ready", in_ready, 0);
        chk("load_busy", busy, 1);
        chk("load_ctl", {ldX, ldTmp, selTmp, clrAcc, ldAcc}, 5'b11010);
        chk("load_coef", coefAddr, 0);
        n_add = 0; n_mul = 0; n_ov = 0; exp_coef = 1;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (ldAcc) n_add++;
            if (out_valid) n_ov++;
            if (ldTmp) begin
                n_mul++;
                chk("mul_sel", selTmp, 1);
                chk("mul_coef", coefAddr, exp_coef);
                exp_coef++;
            end else begin
                chk("nonmul_coef", coefAddr, 0);
            end
        end
        chk("early_out_valid", n_ov, 0);
        step();
        chk("done_out_valid", out_valid, 1);
        chk("done_out_err", out_err, 0);
        chk("n_ldAcc", n_add, 8);
        chk("n_ldTmp", n_mul, 7);
        step();
        chk("back_idle_busy", busy, 0);
        chk("back_idle_ready", in_ready, 1);

        // Backpressure in DONE
        out_ready = 1'b0;
        start_op();
        wait_ov(20, n);
        chk("latency", n, 16);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            step();
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_ldX", ldX, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("release_busy", busy, 0);
        chk("release_out_valid", out_valid, 0);
        step();
        chk("not_remembered_busy", busy, 0);
        start_op();
        chk("next_accept_ldX", ldX, 1);

        // Overflow during 3rd MUL
        repeat (6) step();
        chk("mul3_coef", coefAddr, 3);
        chk("mul3_sel", selTmp, 1);
        ovf = 1'b1;
        step();
        ovf = 1'b0;
        chk("ovf_out_valid", out_valid, 1);
        chk("ovf_out_err", out_err, 1);
        chk("ovf_ldTmp", ldTmp, 0);
        step();
        chk("ovf_idle", busy, 0);
        start_op();
        wait_ov(20, n);
        chk("err_cleared", out_err, 0);
        step();

        // Abort in 2nd ADD
        start_op();
        repeat (3) step();
        chk("add2_ldAcc", ldAcc, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        n_ov = 0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid) n_ov++;
            step();
        end
        chk("abort_no_out_valid", n_ov, 0);

        // Abort together with ovf
        start_op();
        step();
        abort = 1'b1; ovf = 1'b1;
        step();
        abort = 1'b0; ovf = 1'b0;
        chk("abort_ovf_busy", busy, 0);
        chk("abort_ovf_out_valid", out_valid, 0);

        // Abort in IDLE is ignored
        abort = 1'b1; in_valid = 1'b1;
        step();
        abort = 1'b0; in_valid = 1'b0;
        chk("idle_abort_ldX", ldX, 1);
        wait_ov(20, n);
        chk("idle_abort_latency", n, 16);
        step();

        // Asynchronous reset while in MUL
        start_op();
        repeat (2) step();
        chk("pre_rst_coef", coefAddr, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_coef", coefAddr, 0);
        chk("arst_ldTmp", ldTmp, 0);
        #2 rst = 1'b0;
        n_ov = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) n_ov++;
        end
        chk("arst_no_out_valid", n_ov, 0);
        chk("arst_idle", in_ready, 1);

        // Throughput with in_valid and out_ready held high
        in_valid = 1'b1;
        wait_ov(40, n);
        step();
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("throughput", n, 18);
        in_valid = 1'b0;
        step();
        step();
        chk("tp_idle", busy, 0);

        // TERMS = 1 build
        t1_in_valid = 1'b1;
        step();
        t1_in_valid = 1'b0;
        chk("t1_load", {t1_ldX, t1_clrAcc, t1_ldTmp, t1_selTmp}, 4'b1110);
        step();
        chk("t1_add_ldAcc", t1_ldAcc, 1);
        chk("t1_add_coef", t1_coefAddr, 0);
        chk("t1_add_sel", t1_selTmp, 0);
        step();
        chk("t1_out_valid", t1_out_valid, 1);
        chk("t1_out_err", t1_out_err, 0);
        chk("t1_done_mul", {t1_ldTmp, t1_selTmp, t1_coefAddr}, 0);
        step();
        chk("t1_idle", t1_busy, 0);
        chk("t1_idle_ready", t1_in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
